// File: rtl/heavy_part_table_compare0_pkg.sv
// Shared widths, bucket layout and record types for the heavy-part compare stage.
package heavy_part_pkg;
  localparam int KEY_W      = 44;
  localparam int IDX_W      = 12;
  localparam int VOTE_W     = 16;
  localparam int BUCKET_W   = 77;
  localparam int TIME_W     = 64;
  localparam int REQ_W      = TIME_W + KEY_W;
  localparam int EVICT_W    = KEY_W + VOTE_W;
  localparam int LAMBDA_DEF = 8;
  localparam int RD_LAT_DEF = 2;

  // Bucket layout: {key, vote_pos, flag, vote_neg}
  localparam int BKT_KEY_LSB  = 33;
  localparam int BKT_POS_LSB  = 17;
  localparam int BKT_FLAG_BIT = 16;
  localparam int BKT_NEG_LSB  = 0;

  typedef struct packed {
    logic [KEY_W-1:0]  key;
    logic [VOTE_W-1:0] vote_pos;
    logic              flag;
    logic [VOTE_W-1:0] vote_neg;
  } bucket_t;

  typedef struct packed {
    logic [KEY_W-1:0]  key;
    logic [VOTE_W-1:0] count;
  } evict_t;
endpackage

// File: rtl/heavy_part_table_compare0_if.sv
// Request, RAM-port and light-part signals of the heavy-part compare stage.
interface heavy_part_table_compare0_if;
  import heavy_part_pkg::*;

  logic                req_wr;
  logic [REQ_W-1:0]    req_data;
  logic                req_alf;
  logic [BUCKET_W-1:0] ram_rdata;
  logic                ram_wren;
  logic [IDX_W-1:0]    ram_wraddr;
  logic [BUCKET_W-1:0] ram_wrdata;
  logic                evict_wr;
  logic [EVICT_W-1:0]  evict_data;
  logic                evict_alf;

  modport slave (
    input  req_wr, req_data, ram_rdata, evict_alf,
    output req_alf, ram_wren, ram_wraddr, ram_wrdata, evict_wr, evict_data
  );

  modport master (
    output req_wr, req_data, ram_rdata, evict_alf,
    input  req_alf, ram_wren, ram_wraddr, ram_wrdata, evict_wr, evict_data
  );
endinterface

// File: rtl/heavy_part_table_compare0_fwd_hist.sv
// History of the most recent bucket writes; returns the youngest entry whose index matches.
module heavy_part_fwd_hist
  import heavy_part_pkg::*;
#(
  parameter int DEPTH = RD_LAT_DEF + 1,
  parameter int IDX_W = heavy_part_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  bucket_t          push_bkt,
  input  logic [IDX_W-1:0] look_idx,
  output logic             hit,
  output bucket_t          hit_bkt
);
  logic [DEPTH-1:0] vld_h;
  logic [IDX_W-1:0] idx_h [DEPTH];
  bucket_t          bkt_h [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_h <= '0;
    end else begin
      vld_h[0] <= push;
      for (int i = 1; i < DEPTH; i++) vld_h[i] <= vld_h[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_h[0] <= push_idx;
    bkt_h[0] <= push_bkt;
    for (int i = 1; i < DEPTH; i++) begin
      idx_h[i] <= idx_h[i-1];
      bkt_h[i] <= bkt_h[i-1];
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    hit     = 1'b0;
    hit_bkt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_h[i] && idx_h[i] == look_idx) begin
        hit     = 1'b1;
        hit_bkt = bkt_h[i];
      end
    end
  end
endmodule

// File: rtl/heavy_part_table_compare0.sv
// Heavy-part way-0 compare stage: Elastic vote update, RAM write-back and light-part eviction.
// Optional macro LATENCY_MON_EN adds a free-running counter and the lat_max port.
module heavy_part_table_compare0
  import heavy_part_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int LAMBDA = LAMBDA_DEF,
  parameter int IDX_W  = heavy_part_pkg::IDX_W
) (
  input  logic clk,
  input  logic reset,
`ifdef LATENCY_MON_EN
  output logic [15:0] lat_max,
`endif
  heavy_part_table_compare0_if.slave bus
);
  localparam int CMP_W = VOTE_W + $clog2(LAMBDA) + 1;
`ifdef LATENCY_MON_EN
  localparam int ALIGN_W = REQ_W;
`else
  localparam int ALIGN_W = KEY_W;
`endif

  function automatic logic [VOTE_W-1:0] sat_inc(input logic [VOTE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Request alignment with the RAM read latency
  logic [RD_LAT-1:0]  vld_a;
  logic [ALIGN_W-1:0] data_a [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_a <= '0;
    end else begin
      vld_a[0] <= bus.req_wr;
      for (int i = 1; i < RD_LAT; i++) vld_a[i] <= vld_a[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_a[0] <= bus.req_data[ALIGN_W-1:0];
    for (int i = 1; i < RD_LAT; i++) data_a[i] <= data_a[i-1];
  end

  // S0: request meets RAM data, forwarding, vote decision
  logic             vld_p0;
  logic [KEY_W-1:0] key_p0;
  logic [IDX_W-1:0] idx_p0;
  bucket_t          ram_bkt_p0, fwd_bkt_p0, bkt_p0, wr_bkt_p0;
  logic             fwd_hit_p0, ev_vld_p0;
  evict_t           ev_rec_p0;
  logic [VOTE_W-1:0] neg_new_p0;
  logic [CMP_W-1:0]  neg_ext_p0, pos_scaled_p0;

  assign vld_p0 = vld_a[RD_LAT-1];
  assign key_p0 = data_a[RD_LAT-1][KEY_W-1:0];
  assign idx_p0 = key_p0[IDX_W-1:0];

  always_comb begin
    ram_bkt_p0.key      = bus.ram_rdata[BKT_KEY_LSB +: KEY_W];
    ram_bkt_p0.vote_pos = bus.ram_rdata[BKT_POS_LSB +: VOTE_W];
    ram_bkt_p0.flag     = bus.ram_rdata[BKT_FLAG_BIT];
    ram_bkt_p0.vote_neg = bus.ram_rdata[BKT_NEG_LSB +: VOTE_W];
  end

  heavy_part_fwd_hist #(.DEPTH(RD_LAT + 1), .IDX_W(IDX_W)) u_fwd_hist (
    .clk      (clk),
    .reset    (reset),
    .push     (vld_p0),
    .push_idx (idx_p0),
    .push_bkt (wr_bkt_p0),
    .look_idx (idx_p0),
    .hit      (fwd_hit_p0),
    .hit_bkt  (fwd_bkt_p0)
  );

  assign bkt_p0 = fwd_hit_p0 ? fwd_bkt_p0 : ram_bkt_p0;

  // Wide compare keeps LAMBDA*vote_pos exact for any 16-bit vote_pos.
  always_comb begin
    neg_new_p0    = sat_inc(bkt_p0.vote_neg);
    neg_ext_p0    = CMP_W'(neg_new_p0);
    pos_scaled_p0 = CMP_W'(bkt_p0.vote_pos) * CMP_W'(LAMBDA);
    wr_bkt_p0     = bkt_p0;
    ev_vld_p0     = 1'b0;
    ev_rec_p0     = '0;
    if (bkt_p0.vote_pos == '0) begin
      wr_bkt_p0 = '{key: key_p0, vote_pos: 16'd1, flag: 1'b0, vote_neg: 16'd0};
    end else if (bkt_p0.key == key_p0) begin
      wr_bkt_p0.vote_pos = sat_inc(bkt_p0.vote_pos);
    end else if (neg_ext_p0 >= pos_scaled_p0) begin
      wr_bkt_p0 = '{key: key_p0, vote_pos: 16'd1, flag: 1'b1, vote_neg: 16'd0};
      ev_vld_p0 = 1'b1;
      ev_rec_p0 = '{key: bkt_p0.key, count: bkt_p0.vote_pos};
    end else begin
      wr_bkt_p0.vote_neg = neg_new_p0;
      ev_vld_p0 = 1'b1;
      ev_rec_p0 = '{key: key_p0, count: 16'd1};
    end
  end

  // S1: registered write-back, eviction and back-pressure
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.req_alf    <= 1'b0;
      bus.ram_wren   <= 1'b0;
      bus.ram_wraddr <= '0;
      bus.ram_wrdata <= '0;
      bus.evict_wr   <= 1'b0;
      bus.evict_data <= '0;
    end else begin
      bus.req_alf  <= bus.evict_alf;
      bus.ram_wren <= vld_p0;
      bus.evict_wr <= vld_p0 && ev_vld_p0;
      if (vld_p0) begin
        bus.ram_wraddr <= idx_p0;
        bus.ram_wrdata <= wr_bkt_p0;
      end
      if (vld_p0 && ev_vld_p0) bus.evict_data <= ev_rec_p0;
    end
  end

`ifdef LATENCY_MON_EN
  function automatic logic [15:0] sat16(input logic [TIME_W-1:0] v);
    return (|v[TIME_W-1:16]) ? 16'hFFFF : v[15:0];
  endfunction

  logic [TIME_W-1:0] cnt;
  logic [15:0]       age_p0;

  assign age_p0 = sat16(cnt - data_a[RD_LAT-1][REQ_W-1:KEY_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      lat_max <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (vld_p0 && age_p0 > lat_max) lat_max <= age_p0;
    end
  end
`endif
endmodule

// File: tb/tb_heavy_part_table_compare0.sv
// Self-checking bench: vector table plus multi-cycle sequences, scored through an expected-output queue.
`timescale 1ns/1ps
module tb_heavy_part_table_compare0;
  import heavy_part_pkg::*;

  localparam int RD_LAT = 2;
  localparam int LAMBDA = 8;

  typedef struct {
    logic [IDX_W-1:0] addr;
    bucket_t          wr;
    logic             ev;
    evict_t           evd;
    int               due;
  } exp_t;

  typedef struct {
    logic [KEY_W-1:0] key;
    bucket_t          ram;
    bucket_t          wr;
    logic             ev;
    evict_t           evd;
  } vec_t;

  typedef struct {
    int               cyc;
    logic [IDX_W-1:0] idx;
    bucket_t          bkt;
  } hist_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  bit   mon_en = 1'b0;
  exp_t  exp_q[$];
  hist_t mhist[$];
  bucket_t rdl [RD_LAT+1];
  exp_t  mon_e;

  heavy_part_table_compare0_if bus();

`ifdef LATENCY_MON_EN
  logic [15:0] lat_max;
  heavy_part_table_compare0 #(.RD_LAT(RD_LAT), .LAMBDA(LAMBDA)) dut (
    .clk(clk), .reset(reset), .lat_max(lat_max), .bus(bus.slave));
`else
  heavy_part_table_compare0 #(.RD_LAT(RD_LAT), .LAMBDA(LAMBDA)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bucket_t mk(input logic [KEY_W-1:0] k, input logic [15:0] p,
                                 input logic f, input logic [15:0] n);
    bucket_t b;
    b.key = k; b.vote_pos = p; b.flag = f; b.vote_neg = n;
    return b;
  endfunction

  function automatic evict_t mke(input logic [KEY_W-1:0] k, input logic [15:0] c);
    evict_t e;
    e.key = k; e.count = c;
    return e;
  endfunction

  // Reference vote rule in plain integer arithmetic.
  task automatic model(input logic [KEY_W-1:0] key, input bucket_t s,
                       output bucket_t wr, output logic ev, output evict_t evd);
    int nn;
    int pp;
    ev = 1'b0;
    evd = '0;
    nn = (s.vote_neg == 16'hFFFF) ? 65535 : int'(s.vote_neg) + 1;
    pp = (s.vote_pos == 16'hFFFF) ? 65535 : int'(s.vote_pos) + 1;
    if (s.vote_pos == 16'd0) begin
      wr = mk(key, 16'd1, 1'b0, 16'd0);
    end else if (s.key == key) begin
      wr = mk(key, 16'(pp), s.flag, s.vote_neg);
    end else if (nn >= LAMBDA * int'(s.vote_pos)) begin
      wr = mk(key, 16'd1, 1'b1, 16'd0);
      ev = 1'b1;
      evd = mke(s.key, s.vote_pos);
    end else begin
      wr = mk(s.key, s.vote_pos, s.flag, 16'(nn));
      ev = 1'b1;
      evd = mke(key, 16'd1);
    end
  endtask

  // A request sees the youngest earlier write to its index issued within RD_LAT+1 cycles.
  function automatic bucket_t seen(input logic [KEY_W-1:0] key, input bucket_t ram);
    for (int i = mhist.size() - 1; i >= 0; i--)
      if (cyc - mhist[i].cyc <= RD_LAT + 1 && mhist[i].idx == key[IDX_W-1:0])
        return mhist[i].bkt;
    return ram;
  endfunction

  task automatic drive(input logic v, input logic [KEY_W-1:0] key, input bucket_t ram);
    bus.req_wr   = v;
    bus.req_data = {64'(cyc), key};
    for (int i = RD_LAT; i > 0; i--) rdl[i] = rdl[i-1];
    rdl[0] = ram;
    bus.ram_rdata = rdl[RD_LAT];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [KEY_W-1:0] key, input bucket_t wr, input logic ev,
                          input evict_t evd);
    exp_t e;
    hist_t h;
    e.addr = key[IDX_W-1:0]; e.wr = wr; e.ev = ev; e.evd = evd; e.due = cyc + RD_LAT + 1;
    exp_q.push_back(e);
    h.cyc = cyc; h.idx = key[IDX_W-1:0]; h.bkt = wr;
    mhist.push_back(h);
  endtask

  task automatic send(input logic [KEY_W-1:0] key, input bucket_t ram);
    bucket_t wr;
    logic ev;
    evict_t evd;
    drive(1'b1, key, ram);
    model(key, seen(key, ram), wr, ev, evd);
    push_exp(key, wr, ev, evd);
    tick();
  endtask

  task automatic send_vec(input vec_t v);
    drive(1'b1, v.key, v.ram);
    push_exp(v.key, v.wr, v.ev, v.evd);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, '0);
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (bus.ram_wren || bus.evict_wr)) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: wren=%0b evict_wr=%0b addr=%0h, nothing pending",
                 bus.ram_wren, bus.evict_wr, bus.ram_wraddr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency_cycle", 128'(cyc), 128'(mon_e.due));
        chk("ram_wren", 128'(bus.ram_wren), 128'(1));
        chk("ram_wraddr", 128'(bus.ram_wraddr), 128'(mon_e.addr));
        chk("ram_wrdata", 128'(bus.ram_wrdata), 128'(mon_e.wr));
        chk("evict_wr", 128'(bus.evict_wr), 128'(mon_e.ev));
        if (mon_e.ev) chk("evict_data", 128'(bus.evict_data), 128'(mon_e.evd));
      end
    end
  end

  vec_t vecs [8];
  logic [KEY_W-1:0] ka, kb, kc, kr;
  bucket_t ba;
  int c0;

  initial begin
    vecs[0] = '{44'h1_0000_0005, '0, mk(44'h1_0000_0005, 16'd1, 1'b0, 16'd0), 1'b0, '0};
    vecs[1] = '{44'h0_0ABC_0123, mk(44'h0_0ABC_0123, 16'd5, 1'b1, 16'd3),
                mk(44'h0_0ABC_0123, 16'd6, 1'b1, 16'd3), 1'b0, '0};
    vecs[2] = '{44'h5_5555_5777, mk(44'h5_5555_5777, 16'hFFFF, 1'b0, 16'd7),
                mk(44'h5_5555_5777, 16'hFFFF, 1'b0, 16'd7), 1'b0, '0};
    vecs[3] = '{44'h2_0000_0100, mk(44'h3_0000_0100, 16'h2000, 1'b0, 16'hFFFF),
                mk(44'h3_0000_0100, 16'h2000, 1'b0, 16'hFFFF), 1'b1, mke(44'h2_0000_0100, 16'd1)};
    vecs[4] = '{44'hB_0000_0222, mk(44'hA_0000_0222, 16'd2, 1'b0, 16'd14),
                mk(44'hA_0000_0222, 16'd2, 1'b0, 16'd15), 1'b1, mke(44'hB_0000_0222, 16'd1)};
    vecs[5] = '{44'h0_0000_0333, mk(44'h7_0000_0333, 16'd0, 1'b1, 16'd5),
                mk(44'h0_0000_0333, 16'd1, 1'b0, 16'd0), 1'b0, '0};
    vecs[6] = '{44'hD_0000_0444, mk(44'hC_0000_0444, 16'd1, 1'b0, 16'd7),
                mk(44'hD_0000_0444, 16'd1, 1'b1, 16'd0), 1'b1, mke(44'hC_0000_0444, 16'd1)};
    vecs[7] = '{44'hD_0000_0555, mk(44'hC_0000_0555, 16'd1, 1'b0, 16'd6),
                mk(44'hC_0000_0555, 16'd1, 1'b0, 16'd7), 1'b1, mke(44'hD_0000_0555, 16'd1)};

    reset = 1'b1;
    bus.evict_alf = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) rdl[i] = '0;
    drive(1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ram_wren", 128'(bus.ram_wren), 128'(0));
    chk("rst_ram_wraddr", 128'(bus.ram_wraddr), 128'(0));
    chk("rst_ram_wrdata", 128'(bus.ram_wrdata), 128'(0));
    chk("rst_evict_wr", 128'(bus.evict_wr), 128'(0));
    chk("rst_evict_data", 128'(bus.evict_data), 128'(0));
    chk("rst_req_alf", 128'(bus.req_alf), 128'(0));
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_vec(vecs[i]);
      idle(1);
    end
    idle(RD_LAT + 3);

    // Back-to-back same key and forwarding-distance edges
    send(44'h4_0000_0009, '0);
    send(44'h4_0000_0009, '0);
    idle(RD_LAT + 3);
    send(44'h4_0000_0A0A, '0);
    idle(1);
    send(44'h4_0000_0A0A, '0);
    idle(RD_LAT + 3);
    send(44'h4_0000_0C0C, '0);
    idle(2);
    send(44'h4_0000_0C0C, '0);
    idle(RD_LAT + 3);
    send(44'h4_0000_0B0B, '0);
    idle(3);
    send(44'h4_0000_0B0B, '0);
    idle(RD_LAT + 3);

    // Vote-minus then replace on a forwarded bucket
    ka = 44'hA_0000_0888; kb = 44'hB_0000_0888; kc = 44'hC_0000_0888;
    ba = mk(ka, 16'd2, 1'b0, 16'd14);
    send(kb, ba);
    send(kc, ba);
    idle(RD_LAT + 3);

    // Almost-full propagation with requests still arriving
    send(44'h1_0000_0601, mk(44'h9_0000_0601, 16'd5, 1'b0, 16'd0));
    bus.evict_alf = 1'b1;
    drive(1'b1, 44'h1_0000_0602, mk(44'h9_0000_0602, 16'd5, 1'b0, 16'd0));
    begin
      bucket_t w; logic e; evict_t d;
      model(44'h1_0000_0602, seen(44'h1_0000_0602, mk(44'h9_0000_0602, 16'd5, 1'b0, 16'd0)), w, e, d);
      push_exp(44'h1_0000_0602, w, e, d);
    end
    @(negedge clk);
    chk("req_alf_before", 128'(bus.req_alf), 128'(0));
    tick();
    drive(1'b1, 44'h1_0000_0603, mk(44'h9_0000_0603, 16'd5, 1'b0, 16'd0));
    begin
      bucket_t w; logic e; evict_t d;
      model(44'h1_0000_0603, seen(44'h1_0000_0603, mk(44'h9_0000_0603, 16'd5, 1'b0, 16'd0)), w, e, d);
      push_exp(44'h1_0000_0603, w, e, d);
    end
    @(negedge clk);
    chk("req_alf_rise", 128'(bus.req_alf), 128'(1));
    tick();
    send(44'h1_0000_0604, mk(44'h9_0000_0604, 16'd5, 1'b0, 16'd0));
    send(44'h1_0000_0605, mk(44'h9_0000_0605, 16'd5, 1'b0, 16'd0));
    bus.evict_alf = 1'b0;
    idle(1);
    @(negedge clk);
    chk("req_alf_fall", 128'(bus.req_alf), 128'(0));
    idle(RD_LAT + 3);

    // Reset with requests in flight
    kr = 44'h6_0000_00CC;
    send(kr, '0);
    send(kr, '0);
    send(kr, '0);
    mon_en = 1'b0;
    reset = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    exp_q.delete();
    mhist.delete();
    for (int i = 0; i <= RD_LAT; i++) rdl[i] = '0;
    reset = 1'b0;
    mon_en = 1'b1;
    c0 = out_cnt;
    idle(RD_LAT + 4);
    chk("no_output_after_reset", 128'(out_cnt - c0), 128'(0));
    send(kr, '0);
    idle(RD_LAT + 4);

    chk("pending_left", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
